// File: rtl/wshb_frame_reader_if.sv
// Purpose: pipelined 16-bit Wishbone (B4) read bus between the frame reader and the SDRAM controller.
// Latency: none; wires only.
// Backpressure: the slave throttles requests with stall; it returns one ack per accepted request.
//
// Signals
//   adr    master->slave  32  byte address
//   cyc    master->slave   1  bus cycle in progress
//   stb    master->slave   1  request strobe
//   we     master->slave   1  write enable
//   sel    master->slave   2  byte lane select
//   dat_w  master->slave  16  write data
//   dat_r  slave->master  16  read data, valid with ack
//   ack    slave->master   1  request completed
//   stall  slave->master   1  request not accepted this cycle
interface wshb_frame_reader_if;
    logic [31:0] adr;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [1:0]  sel;
    logic [15:0] dat_w;
    logic [15:0] dat_r;
    logic        ack;
    logic        stall;

    modport master (
        output adr, cyc, stb, we, sel, dat_w,
        input  dat_r, ack, stall
    );

    modport slave (
        input  adr, cyc, stb, we, sel, dat_w,
        output dat_r, ack, stall
    );
endinterface

// File: rtl/wshb_frame_reader.sv
// Purpose: Wishbone read master that streams a HDISP x VDISP RGB565 framebuffer in fixed bursts into a pixel FIFO.
// Latency: a pixel acked at edge N is presented on pix_data one cycle later when the FIFO was empty.
// Backpressure: a burst starts only when the FIFO can absorb all of it; pix_ready low simply stops bursts.
//
// sync_fifo ports
//   clk, rst          clock, synchronous active-high reset
//   wr_vld, wr_dat    push strobe and data (caller guarantees not full)
//   rd_rdy            pop when rd_vld is also high
//   rd_vld, rd_dat    first-word fall-through head
//   level             current occupancy
//
// wshb_frame_reader ports
//   CLK, RST          wshb clock, synchronous active-high reset
//   enable            1: keep fetching frames; 0: stop after the current burst
//   wb                Wishbone master modport
//   pix_data          pixel at FIFO head
//   pix_sof           head is pixel 0 of a frame
//   pix_valid         FIFO not empty
//   pix_ready         consumer accepts the head pixel

// Purpose: generic synchronous first-word fall-through FIFO.
// Latency: a pushed word is visible at rd_dat the cycle after the push.
// Backpressure: none internally; the writer must never push into a full FIFO.
module sync_fifo #(
    parameter int WIDTH = 17,
    parameter int DEPTH = 64,
    parameter int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_vld,
    input  logic [WIDTH-1:0] wr_dat,
    input  logic             rd_rdy,
    output logic             rd_vld,
    output logic [WIDTH-1:0] rd_dat,
    output logic [LVL_W-1:0] level
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             pop;

    assign rd_vld = (level != '0);
    assign rd_dat = mem[rd_ptr];
    assign pop    = rd_vld & rd_rdy;

    // Storage needs no reset: nothing is read before it has been written.
    always_ff @(posedge clk) begin
        if (wr_vld) begin
            mem[wr_ptr] <= wr_dat;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_vld) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            unique case ({wr_vld, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end
endmodule

module wshb_frame_reader #(
    parameter int          HDISP      = 640,
    parameter int          VDISP      = 480,
    parameter logic [31:0] BASE_ADDR  = 32'd0,
    parameter int          BURST_LEN  = 16,
    parameter int          FIFO_DEPTH = 64
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  enable,
    wshb_frame_reader_if.master   wb,
    output logic [15:0]           pix_data,
    output logic                  pix_sof,
    output logic                  pix_valid,
    input  logic                  pix_ready
);
    localparam int NPIX  = HDISP * VDISP;
    localparam int IDX_W = $clog2(NPIX);
    localparam int LVL_W = $clog2(FIFO_DEPTH) + 1;
    localparam int BC_W  = $clog2(BURST_LEN) + 1;

    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NPIX - 1);
    localparam logic [BC_W-1:0]  LAST_BEAT = BC_W'(BURST_LEN - 1);
    localparam logic [31:0]      BURST_U   = 32'(BURST_LEN);
    localparam logic [31:0]      DEPTH_U   = 32'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t           state;
    logic             cyc_q;
    logic             stb_q;
    logic [31:0]      adr_q;
    logic [IDX_W-1:0] pix_idx;
    logic [BC_W-1:0]  issued;
    logic [BC_W-1:0]  acked;
    logic [BC_W-1:0]  outstanding;
    logic             burst_sof;

    logic             accept;
    logic             ack_vld;
    logic             credit_ok;
    logic [31:0]      credit_sum;
    logic             fifo_pop;
    logic [16:0]      fifo_wr_dat;
    logic [16:0]      fifo_head;
    logic [LVL_W-1:0] fifo_level;

    // Read-only master: write side of the bus is constant.
    assign wb.adr   = adr_q;
    assign wb.cyc   = cyc_q;
    assign wb.stb   = stb_q;
    assign wb.we    = 1'b0;
    assign wb.sel   = 2'b11;
    assign wb.dat_w = 16'h0000;

    assign accept  = stb_q & ~wb.stall;
    // Acks outside a bus cycle (e.g. stragglers after a reset) are dropped.
    assign ack_vld = wb.ack & cyc_q;

    // A burst may only start if every word already in flight plus the whole
    // new burst fits, so a push can never hit a full FIFO.
    assign credit_sum = 32'(fifo_level) + 32'(outstanding) + BURST_U;
    assign credit_ok  = (credit_sum <= DEPTH_U);

    // Bursts never straddle a frame, so pixel 0 is always the first word of
    // its burst: the burst-level flag plus "first ack" identifies it.
    assign fifo_wr_dat = {burst_sof && (acked == '0), wb.dat_r};
    assign fifo_pop    = pix_valid & pix_ready;

    sync_fifo #(
        .WIDTH (17),
        .DEPTH (FIFO_DEPTH),
        .LVL_W (LVL_W)
    ) u_fifo (
        .clk    (CLK),
        .rst    (RST),
        .wr_vld (ack_vld),
        .wr_dat (fifo_wr_dat),
        .rd_rdy (pix_ready),
        .rd_vld (pix_valid),
        .rd_dat (fifo_head),
        .level  (fifo_level)
    );

    assign pix_data = fifo_head[15:0];
    assign pix_sof  = fifo_head[16] & pix_valid;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            cyc_q       <= 1'b0;
            stb_q       <= 1'b0;
            adr_q       <= BASE_ADDR;
            pix_idx     <= '0;
            issued      <= '0;
            acked       <= '0;
            outstanding <= '0;
            burst_sof   <= 1'b0;
        end else begin
            // Accept and ack in the same cycle leave outstanding unchanged.
            unique case ({accept, ack_vld})
                2'b10:   outstanding <= outstanding + BC_W'(1);
                2'b01:   outstanding <= outstanding - BC_W'(1);
                default: outstanding <= outstanding;
            endcase

            if (ack_vld) begin
                acked <= acked + BC_W'(1);
            end

            unique case (state)
                IDLE: begin
                    if (enable && credit_ok) begin
                        state     <= REQ;
                        cyc_q     <= 1'b1;
                        stb_q     <= 1'b1;
                        issued    <= '0;
                        acked     <= '0;
                        burst_sof <= (pix_idx == '0);
                    end
                end

                REQ: begin
                    // While stalled nothing moves, so stb and adr hold.
                    if (accept) begin
                        issued <= issued + BC_W'(1);
                        if (pix_idx == LAST_IDX) begin
                            pix_idx <= '0;
                            adr_q   <= BASE_ADDR;
                        end else begin
                            pix_idx <= pix_idx + IDX_W'(1);
                            adr_q   <= adr_q + 32'd2;
                        end
                        if (issued == LAST_BEAT) begin
                            state <= WAIT;
                            stb_q <= 1'b0;
                        end
                    end
                end

                WAIT: begin
                    if (ack_vld && (acked == LAST_BEAT)) begin
                        state <= IDLE;
                        cyc_q <= 1'b0;
                    end
                end

                default: begin
                    state <= IDLE;
                    cyc_q <= 1'b0;
                    stb_q <= 1'b0;
                end
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge CLK) disable iff (RST)
        !(ack_vld && !fifo_pop && (fifo_level == LVL_W'(FIFO_DEPTH))));

    a_outstanding_bound: assert property (@(posedge CLK) disable iff (RST)
        (outstanding <= BC_W'(BURST_LEN)));

    a_stb_in_cyc: assert property (@(posedge CLK) disable iff (RST)
        (!stb_q || cyc_q));
endmodule

// File: tb/tb_wshb_frame_reader.sv
// Purpose: directed scoreboard bench for wshb_frame_reader, two parameterisations on one clock.
// Latency: slave model acks one cycle after each accepted request.
// Backpressure: stall and pix_ready are driven per test; monitors pop expected queues on each handshake.
module tb_wshb_frame_reader;
    localparam logic [31:0] BASE_A = 32'h0000_1000;
    localparam int          NPIX_A = 640 * 480;
    localparam logic [31:0] BASE_B = 32'h0000_0200;
    localparam int          NPIX_B = 8 * 2;

    logic CLK;
    logic RST;
    logic en_a, en_b;
    logic stall_a, stall_b;
    logic rdy_a, rdy_b;
    logic inj_a;
    logic ack_r_a, ack_r_b;
    logic [15:0] dat_r_a, dat_r_b;
    logic [15:0] pd_a, pd_b;
    logic ps_a, ps_b, pv_a, pv_b;

    int total = 0;
    int bad   = 0;
    int acc_a = 0, acc_b = 0, ack_a = 0, sof_b = 0;
    int a0, k0, b0;

    logic [31:0] exp_adr_a[$];
    logic [31:0] exp_adr_b[$];
    logic [16:0] exp_pix_a[$];
    logic [16:0] exp_pix_b[$];

    wshb_frame_reader_if wb_a ();
    wshb_frame_reader_if wb_b ();

    wshb_frame_reader #(
        .HDISP(640), .VDISP(480), .BASE_ADDR(BASE_A), .BURST_LEN(16), .FIFO_DEPTH(64)
    ) dut_a (
        .CLK(CLK), .RST(RST), .enable(en_a), .wb(wb_a),
        .pix_data(pd_a), .pix_sof(ps_a), .pix_valid(pv_a), .pix_ready(rdy_a)
    );

    wshb_frame_reader #(
        .HDISP(8), .VDISP(2), .BASE_ADDR(BASE_B), .BURST_LEN(4), .FIFO_DEPTH(8)
    ) dut_b (
        .CLK(CLK), .RST(RST), .enable(en_b), .wb(wb_b),
        .pix_data(pd_b), .pix_sof(ps_b), .pix_valid(pv_b), .pix_ready(rdy_b)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Memory contents as a function of byte address.
    function automatic logic [15:0] memf(input logic [31:0] a);
        return a[16:1] ^ 16'hC35A;
    endfunction

    // Slave models: pipelined, never self-stall unless told, ack one cycle after accept.
    always @(posedge CLK) begin
        ack_r_a <= wb_a.cyc && wb_a.stb && !stall_a;
        dat_r_a <= memf(wb_a.adr);
        ack_r_b <= wb_b.cyc && wb_b.stb && !stall_b;
        dat_r_b <= memf(wb_b.adr);
    end

    assign wb_a.ack   = ack_r_a | inj_a;
    assign wb_a.dat_r = dat_r_a;
    assign wb_a.stall = stall_a;
    assign wb_b.ack   = ack_r_b;
    assign wb_b.dat_r = dat_r_b;
    assign wb_b.stall = stall_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    function automatic void push_req_a(input int first, input int n);
        for (int k = 0; k < n; k++)
            exp_adr_a.push_back(BASE_A + 32'(2 * ((first + k) % NPIX_A)));
    endfunction

    function automatic void push_pix_a(input int first, input int n);
        for (int k = 0; k < n; k++) begin
            int idx = (first + k) % NPIX_A;
            exp_pix_a.push_back({idx == 0, memf(BASE_A + 32'(2 * idx))});
        end
    endfunction

    function automatic void push_req_b(input int first, input int n);
        for (int k = 0; k < n; k++)
            exp_adr_b.push_back(BASE_B + 32'(2 * ((first + k) % NPIX_B)));
    endfunction

    function automatic void push_pix_b(input int first, input int n);
        for (int k = 0; k < n; k++) begin
            int idx = (first + k) % NPIX_B;
            exp_pix_b.push_back({idx == 0, memf(BASE_B + 32'(2 * idx))});
        end
    endfunction

    // Monitors: compare every accepted request and every popped pixel.
    always @(negedge CLK) begin
        if (wb_a.cyc === 1'b1 && wb_a.stb === 1'b1 && !stall_a) begin
            acc_a++;
            if (exp_adr_a.size() == 0) fail_now("adr_a_extra");
            else check("adr_a", wb_a.adr, exp_adr_a.pop_front());
        end
        if (wb_a.cyc === 1'b1 && wb_a.ack === 1'b1) ack_a++;
        if (pv_a === 1'b1 && rdy_a) begin
            if (exp_pix_a.size() == 0) fail_now("pix_a_extra");
            else begin
                logic [16:0] e;
                e = exp_pix_a.pop_front();
                check("pix_a_data", pd_a, e[15:0]);
                check("pix_a_sof", ps_a, e[16]);
            end
        end
    end

    always @(negedge CLK) begin
        if (wb_b.cyc === 1'b1 && wb_b.stb === 1'b1 && !stall_b) begin
            acc_b++;
            if (exp_adr_b.size() == 0) fail_now("adr_b_extra");
            else check("adr_b", wb_b.adr, exp_adr_b.pop_front());
        end
        if (pv_b === 1'b1 && rdy_b) begin
            if (exp_pix_b.size() == 0) fail_now("pix_b_extra");
            else begin
                logic [16:0] e;
                e = exp_pix_b.pop_front();
                if (e[16]) sof_b++;
                check("pix_b_data", pd_b, e[15:0]);
                check("pix_b_sof", ps_b, e[16]);
            end
        end
    end

    task automatic wait_cyc_a(input logic val, input int bound, input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge CLK);
            if (wb_a.cyc === val) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1);
    endtask

    task automatic drain(input int which, input int bound, input string name);
        logic ok;
        ok = 1'b0;
        for (int i = 0; i < bound; i++) begin
            @(negedge CLK);
            if ((which == 0 ? exp_pix_a.size() : exp_pix_b.size()) == 0) begin
                ok = 1'b1;
                break;
            end
        end
        check(name, ok, 1);
        @(posedge CLK);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; en_a = 1'b1; en_b = 1'b0;
        stall_a = 1'b0; stall_b = 1'b0; rdy_a = 1'b0; rdy_b = 1'b0; inj_a = 1'b0;

        // Reset held three cycles with enable high.
        repeat (3) begin
            @(negedge CLK);
            check("rst_cyc", wb_a.cyc, 0);
            check("rst_stb", wb_a.stb, 0);
            check("rst_valid", pv_a, 0);
            check("rst_adr", wb_a.adr, BASE_A);
        end
        check("tie_we", wb_a.we, 0);
        check("tie_sel", wb_a.sel, 2'b11);
        check("tie_dat", wb_a.dat_w, 0);

        // One clean burst: 16 back-to-back requests, 16 acks, sof on word 0.
        @(posedge CLK);
        #1 RST = 1'b0;
        rdy_a = 1'b1;
        push_req_a(0, 16);
        push_pix_a(0, 16);
        a0 = acc_a; k0 = ack_a;
        wait_cyc_a(1'b1, 10, "t2_start");
        en_a = 1'b0;
        for (int i = 0; i < 16; i++) begin
            check("t2_stb_run", wb_a.stb, 1);
            @(negedge CLK);
        end
        check("t2_stb_drop", wb_a.stb, 0);
        check("t2_wait_cyc", wb_a.cyc, 1);
        @(negedge CLK);
        check("t2_cyc_low", wb_a.cyc, 0);
        drain(0, 40, "t2_drain");
        check("t2_accepts", acc_a - a0, 16);
        check("t2_acks", ack_a - k0, 16);

        // Stall the third request for five cycles.
        pulse_reset();
        en_a = 1'b1;
        push_req_a(0, 16);
        push_pix_a(0, 16);
        a0 = acc_a;
        wait_cyc_a(1'b1, 10, "t3_start");
        en_a = 1'b0;
        @(posedge CLK);
        @(posedge CLK);
        #1 stall_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("t3_stall_stb", wb_a.stb, 1);
            check("t3_stall_adr", wb_a.adr, BASE_A + 32'd4);
            @(posedge CLK);
            #1;
        end
        stall_a = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        check("t3_resume_adr", wb_a.adr, BASE_A + 32'd6);
        drain(0, 60, "t3_drain");
        check("t3_accepts", acc_a - a0, 16);

        // Consumer blocked: four bursts fill the FIFO, then fetching stops.
        pulse_reset();
        rdy_a = 1'b0;
        en_a = 1'b1;
        push_req_a(0, 80);
        a0 = acc_a;
        repeat (150) @(posedge CLK);
        #1;
        check("t4_fill_accepts", acc_a - a0, 64);
        check("t4_idle_cyc", wb_a.cyc, 0);
        check("t4_full_valid", pv_a, 1);
        push_pix_a(0, 16);
        rdy_a = 1'b1;
        repeat (16) @(posedge CLK);
        #1 rdy_a = 1'b0;
        wait_cyc_a(1'b1, 10, "t4_refill_start");
        check("t4_refill_adr", wb_a.adr, BASE_A + 32'd128);
        en_a = 1'b0;
        wait_cyc_a(1'b0, 40, "t4_refill_done");
        push_pix_a(16, 64);
        rdy_a = 1'b1;
        drain(0, 200, "t4_drain");
        check("t4_accepts", acc_a - a0, 80);

        // enable dropped after the second accept: burst still completes.
        push_req_a(80, 16);
        push_pix_a(80, 16);
        a0 = acc_a;
        en_a = 1'b1;
        wait_cyc_a(1'b1, 10, "t6_start");
        @(posedge CLK);
        @(posedge CLK);
        #1 en_a = 1'b0;
        wait_cyc_a(1'b0, 40, "t6_done");
        @(posedge CLK);
        #1;
        check("t6_full_burst", acc_a - a0, 16);
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            check("t6_idle", wb_a.cyc, 0);
        end
        drain(0, 40, "t6_drain");

        // Resume from the kept position, then reset in the middle of the burst.
        rdy_a = 1'b0;
        push_req_a(96, 16);
        en_a = 1'b1;
        wait_cyc_a(1'b1, 10, "t6_resume_start");
        check("t6_resume_adr", wb_a.adr, BASE_A + 32'd192);
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        en_a = 1'b0;
        @(posedge CLK);
        #1 RST = 1'b0;
        @(negedge CLK);
        check("t6_rst_cyc", wb_a.cyc, 0);
        check("t6_rst_stb", wb_a.stb, 0);
        check("t6_rst_valid", pv_a, 0);
        check("t6_rst_adr", wb_a.adr, BASE_A);
        @(posedge CLK);
        #1 inj_a = 1'b1;
        repeat (3) @(posedge CLK);
        #1 inj_a = 1'b0;
        check("t6_late_ack", pv_a, 0);
        exp_adr_a.delete();
        push_req_a(0, 16);
        push_pix_a(0, 16);
        rdy_a = 1'b1;
        en_a = 1'b1;
        wait_cyc_a(1'b1, 10, "t6_restart");
        check("t6_restart_adr", wb_a.adr, BASE_A);
        en_a = 1'b0;
        drain(0, 60, "t6_restart_drain");

        // Small frame: 16 pixels, bursts of 4; the 17th request wraps to BASE.
        push_req_b(0, 20);
        push_pix_b(0, 20);
        b0 = acc_b;
        rdy_b = 1'b1;
        en_b = 1'b1;
        begin
            logic hit;
            hit = 1'b0;
            for (int i = 0; i < 300; i++) begin
                @(posedge CLK);
                #1;
                if (acc_b - b0 >= 17) begin
                    hit = 1'b1;
                    break;
                end
            end
            check("t5_reach_17", hit, 1);
        end
        en_b = 1'b0;
        drain(1, 100, "t5_drain");
        repeat (5) @(posedge CLK);
        #1;
        check("t5_accepts", acc_b - b0, 20);
        check("t5_sof_count", sof_b, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
